// File: rtl/pcm_dac_pkg.sv
// Shared constants, types and helpers for the PCM sigma-delta DAC slice.
// Imported by fifo, sigma_delta_mod and pcm_sigma_delta_dac.
package pcm_dac_pkg;

    localparam int unsigned MAX_CHANNELS = 8;
    localparam int unsigned MAX_SAMPLE_W = 24;
    localparam int unsigned MAX_FRAME_W  = MAX_CHANNELS * MAX_SAMPLE_W;

    // What a sample-period tick does this cycle.
    typedef enum logic [1:0] {
        TICK_IDLE,
        TICK_POP,
        TICK_UNDERRUN
    } tick_act_e;

    function automatic int unsigned level_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

    // Signed two's complement to offset binary: invert the sign bit of a w-bit sample.
    function automatic logic [MAX_SAMPLE_W-1:0] to_offset_bin(
        input logic [MAX_SAMPLE_W-1:0] s,
        input int unsigned             w
    );
        return s ^ (MAX_SAMPLE_W'(1) << (w - 1));
    endfunction

    function automatic logic [MAX_SAMPLE_W-1:0] frame_chan(
        input logic [MAX_FRAME_W-1:0] frame,
        input int unsigned            k,
        input int unsigned            w
    );
        logic [MAX_FRAME_W-1:0] shifted;
        shifted = frame >> (k * w);
        return MAX_SAMPLE_W'(shifted) & ((MAX_SAMPLE_W'(1) << w) - MAX_SAMPLE_W'(1));
    endfunction

endpackage

// File: rtl/fifo.sv
// Synchronous FIFO with first-word-fall-through read and occupancy count.
// Writes while full and reads while empty are ignored.
module fifo
    import pcm_dac_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned DEPTH      = 1024
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        i_wr_en,
    input  logic [DATA_WIDTH-1:0]       i_wr_data,
    input  logic                        i_rd_en,
    output logic [DATA_WIDTH-1:0]       o_rd_data,
    output logic                        o_full,
    output logic                        o_empty,
    output logic [level_w(DEPTH)-1:0]   o_level
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned LW = level_w(DEPTH);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]         r_wr_ptr;
    logic [AW-1:0]         r_rd_ptr;
    logic [LW-1:0]         r_level;
    logic                  w_push;
    logic                  w_pop;

    assign o_full    = (r_level == LW'(DEPTH));
    assign o_empty   = (r_level == '0);
    assign w_push    = i_wr_en & ~o_full;
    assign w_pop     = i_rd_en & ~o_empty;
    assign o_rd_data = r_mem[r_rd_ptr];
    assign o_level   = r_level;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_level  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + LW'(1);
                2'b01:   r_level <= r_level - LW'(1);
                default: r_level <= r_level;
            endcase
        end
    end

endmodule

// File: rtl/sigma_delta_mod.sv
// First-order sigma-delta modulator: accumulates the offset-binary sample and
// emits the registered carry-out as a 1-bit density stream.
module sigma_delta_mod
    import pcm_dac_pkg::*;
#(
    parameter int unsigned SAMPLE_W = 16
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                i_en,
    input  logic [SAMPLE_W-1:0] i_sample,
    output logic                o_pwm
);

    logic [SAMPLE_W-1:0] w_u;
    logic [SAMPLE_W:0]   r_acc;

    assign w_u = SAMPLE_W'(to_offset_bin(MAX_SAMPLE_W'(i_sample), SAMPLE_W));

    // Carry of the previous add is dropped before the next add, so it wraps naturally.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_acc <= '0;
        end else if (i_en) begin
            r_acc <= {1'b0, r_acc[SAMPLE_W-1:0]} + {1'b0, w_u};
        end
    end

    assign o_pwm = i_en & r_acc[SAMPLE_W];

endmodule

// File: rtl/pcm_sigma_delta_dac.sv
// Multi-channel PCM sigma-delta DAC: frame FIFO, sample-rate tick, per-channel modulators.
// Optional PCM_DAC_VOLUME_EN adds vol_i scaling with one extra pipeline stage.
module pcm_sigma_delta_dac
    import pcm_dac_pkg::*;
#(
    parameter int unsigned CHANNELS = 2,
    parameter int unsigned SAMPLE_W = 16,
    parameter int unsigned DEPTH    = 1024,
    parameter int unsigned DIV_W    = 18
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           en_i,
    input  logic [DIV_W-1:0]               div_i,
    input  logic                           we,
    input  logic [CHANNELS*SAMPLE_W-1:0]   pcm_i,
    input  logic                           clr_underrun_i,
`ifdef PCM_DAC_VOLUME_EN
    input  logic [7:0]                     vol_i,
`endif
    output logic                           fifo_full,
    output logic [level_w(DEPTH)-1:0]      fifo_level,
    output logic                           underrun_o,
    output logic [CHANNELS-1:0]            pwm_o
);

    localparam int unsigned FRAME_W = CHANNELS * SAMPLE_W;

    logic [DIV_W-1:0]   r_cnt;
    logic               w_tick;
    logic               w_empty;
    logic [FRAME_W-1:0] w_head;
    logic [FRAME_W-1:0] r_frame;
    logic               r_underrun;
    tick_act_e          w_act;

    assign w_tick = en_i & (r_cnt >= div_i);

    always_comb begin
        w_act = TICK_IDLE;
        if (w_tick) begin
            w_act = w_empty ? TICK_UNDERRUN : TICK_POP;
        end
    end

    // ">=" lets the counter recover immediately if div_i is lowered below r_cnt.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= '0;
        end else if (w_tick) begin
            r_cnt <= '0;
        end else if (en_i) begin
            r_cnt <= r_cnt + DIV_W'(1);
        end
    end

    fifo #(
        .DATA_WIDTH (FRAME_W),
        .DEPTH      (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (we),
        .i_wr_data (pcm_i),
        .i_rd_en   (w_act == TICK_POP),
        .o_rd_data (w_head),
        .o_full    (fifo_full),
        .o_empty   (w_empty),
        .o_level   (fifo_level)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            r_frame <= '0;
        end else if (w_act == TICK_POP) begin
            r_frame <= w_head;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_underrun <= 1'b0;
        end else if (w_act == TICK_UNDERRUN) begin
            r_underrun <= 1'b1;
        end else if (clr_underrun_i) begin
            r_underrun <= 1'b0;
        end
    end

    assign underrun_o = r_underrun;

    for (genvar k = 0; k < CHANNELS; k++) begin : g_chan
        logic [SAMPLE_W-1:0] w_s;
        logic [SAMPLE_W-1:0] w_mod_in;

        assign w_s = SAMPLE_W'(frame_chan(MAX_FRAME_W'(r_frame), k, SAMPLE_W));

`ifdef PCM_DAC_VOLUME_EN
        logic signed [SAMPLE_W+8:0] w_prod;
        logic        [SAMPLE_W-1:0] r_scaled;

        assign w_prod = (SAMPLE_W+9)'($signed(w_s)) * (SAMPLE_W+9)'($signed({1'b0, vol_i}));

        always_ff @(posedge clk) begin
            if (reset) begin
                r_scaled <= '0;
            end else begin
                r_scaled <= SAMPLE_W'(w_prod >>> 8);
            end
        end

        assign w_mod_in = r_scaled;
`else
        assign w_mod_in = w_s;
`endif

        sigma_delta_mod #(
            .SAMPLE_W (SAMPLE_W)
        ) u_mod (
            .clk      (clk),
            .reset    (reset),
            .i_en     (en_i),
            .i_sample (w_mod_in),
            .o_pwm    (pwm_o[k])
        );
    end

endmodule

// File: tb/tb_pcm_sigma_delta_dac.sv
// Directed self-checking bench for pcm_sigma_delta_dac (CHANNELS=2, SAMPLE_W=16, DEPTH=1024).
// Expected values are hand-derived from the accumulator and tick-counter arithmetic.
module tb_pcm_sigma_delta_dac;

    localparam int unsigned CHANNELS = 2;
    localparam int unsigned SAMPLE_W = 16;
    localparam int unsigned DEPTH    = 1024;
    localparam int unsigned DIV_W    = 18;
    localparam int unsigned LW       = $clog2(DEPTH + 1);

    logic                         clk = 1'b0;
    logic                         reset;
    logic                         en_i;
    logic [DIV_W-1:0]             div_i;
    logic                         we;
    logic [CHANNELS*SAMPLE_W-1:0] pcm_i;
    logic                         clr_underrun_i;
`ifdef PCM_DAC_VOLUME_EN
    logic [7:0]                   vol_i;
`endif
    logic                         fifo_full;
    logic [LW-1:0]                fifo_level;
    logic                         underrun_o;
    logic [CHANNELS-1:0]          pwm_o;

    int n_cmp = 0;
    int n_err = 0;
    int h0;
    int h1;

    pcm_sigma_delta_dac #(
        .CHANNELS (CHANNELS),
        .SAMPLE_W (SAMPLE_W),
        .DEPTH    (DEPTH),
        .DIV_W    (DIV_W)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .en_i           (en_i),
        .div_i          (div_i),
        .we             (we),
        .pcm_i          (pcm_i),
        .clr_underrun_i (clr_underrun_i),
`ifdef PCM_DAC_VOLUME_EN
        .vol_i          (vol_i),
`endif
        .fifo_full      (fifo_full),
        .fifo_level     (fifo_level),
        .underrun_o     (underrun_o),
        .pwm_o          (pwm_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic push_n(input logic [31:0] f, input int n);
        pcm_i = f;
        we    = 1'b1;
        cyc(n);
        we    = 1'b0;
    endtask

    task automatic do_reset();
        reset          = 1'b1;
        en_i           = 1'b0;
        we             = 1'b0;
        clr_underrun_i = 1'b0;
        div_i          = '0;
        cyc(1);
        reset          = 1'b0;
    endtask

    initial begin
        reset          = 1'b1;
        en_i           = 1'b0;
        div_i          = '0;
        we             = 1'b0;
        pcm_i          = '0;
        clr_underrun_i = 1'b0;
`ifdef PCM_DAC_VOLUME_EN
        vol_i          = 8'd128;
`endif
        cyc(3);
        check("rst_level",    32'(fifo_level), 32'd0);
        check("rst_full",     32'(fifo_full),  32'd0);
        check("rst_underrun", 32'(underrun_o), 32'd0);
        check("rst_pwm",      32'(pwm_o),      32'd0);
        reset = 1'b0;

        // Full-scale frames, one pop per 10 cycles, 65536-cycle duty count.
        div_i = 18'd9;
        push_n(32'h8000_7FFF, 4);
        check("t1_level4", 32'(fifo_level), 32'd4);
        en_i = 1'b1;
        cyc(9);
        check("t1_no_tick_yet", 32'(fifo_level), 32'd4);
        cyc(1);
        check("t1_first_pop", 32'(fifo_level), 32'd3);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < 65536; i++) begin
            cyc(1);
            h0 += int'(pwm_o[0]);
            h1 += int'(pwm_o[1]);
            if (i == 9) check("t1_second_pop", 32'(fifo_level), 32'd2);
        end
        check("t1_ch0_high", 32'(h0), 32'd65535);
        check("t1_ch1_high", 32'(h1), 32'd0);
        check("t1_drained",  32'(fifo_level), 32'd0);
        check("t1_underrun", 32'(underrun_o), 32'd1);

        // Midscale sample gives a period-2 bitstream; pause forces low and holds state.
        do_reset();
        push_n(32'h0000_0000, 1);
        en_i = 1'b1;
        for (int i = 0; i < 4; i++) begin
            cyc(1);
            check("t2_alt", 32'(pwm_o), (i % 2 == 1) ? 32'd3 : 32'd0);
        end
        check("t2_popped", 32'(fifo_level), 32'd0);
        en_i = 1'b0;
        #1;
        check("t2_pause_force", 32'(pwm_o), 32'd0);
        cyc(1);
        check("t2_pause_hold", 32'(pwm_o), 32'd0);
        en_i = 1'b1;
        #1;
        check("t2_resume", 32'(pwm_o), 32'd3);

        // Fill to DEPTH, drop on full, FIFO order preserved.
        do_reset();
        push_n(32'h8000_7FFF, 1);
        push_n(32'h7FFF_8000, 1022);
        check("t3_level_1023", 32'(fifo_level), 32'd1023);
        check("t3_not_full",   32'(fifo_full),  32'd0);
        push_n(32'h7FFF_8000, 1);
        check("t3_level_full", 32'(fifo_level), 32'd1024);
        check("t3_full",       32'(fifo_full),  32'd1);
        push_n(32'h0000_0000, 1);
        check("t3_drop", 32'(fifo_level), 32'd1024);
        en_i = 1'b1;
        cyc(1);
        div_i = 18'd1000;
        check("t3_pop1", 32'(fifo_level), 32'd1023);
        cyc(1);
        check("t3_first_frame_a", 32'(pwm_o), 32'd1);
        cyc(1);
        check("t3_first_frame_b", 32'(pwm_o), 32'd1);

        // Underrun: sticky, frame held, clear, set-wins, push on underrun tick kept.
        do_reset();
        push_n(32'h8000_7FFF, 1);
        en_i = 1'b1;
        cyc(1);
        check("t4_pop_level", 32'(fifo_level), 32'd0);
        check("t4_no_underrun", 32'(underrun_o), 32'd0);
        cyc(1);
        check("t4_underrun", 32'(underrun_o), 32'd1);
        cyc(1);
        check("t4_frame_held", 32'(pwm_o), 32'd1);
        en_i           = 1'b0;
        we             = 1'b1;
        clr_underrun_i = 1'b1;
        cyc(1);
        check("t4_cleared", 32'(underrun_o), 32'd0);
        check("t4_push_lvl", 32'(fifo_level), 32'd1);
        we             = 1'b0;
        clr_underrun_i = 1'b0;
        en_i           = 1'b1;
        cyc(1);
        check("t4_pop2", 32'(fifo_level), 32'd0);
        cyc(1);
        check("t4_underrun2", 32'(underrun_o), 32'd1);
        clr_underrun_i = 1'b1;
        we             = 1'b1;
        cyc(1);
        check("t4_set_wins", 32'(underrun_o), 32'd1);
        check("t4_push_on_underrun", 32'(fifo_level), 32'd1);
        we   = 1'b0;
        en_i = 1'b0;
        cyc(1);
        check("t4_clear_idle", 32'(underrun_o), 32'd0);

        // Divider shrinks below the running count.
        do_reset();
        push_n(32'h1234_5678, 4);
        div_i = 18'd100;
        en_i  = 1'b1;
        cyc(50);
        check("t5_cnt50", 32'(fifo_level), 32'd4);
        div_i = 18'd5;
        cyc(1);
        check("t5_recover", 32'(fifo_level), 32'd3);
        cyc(5);
        check("t5_no_early", 32'(fifo_level), 32'd3);
        cyc(1);
        check("t5_period6_a", 32'(fifo_level), 32'd2);
        cyc(6);
        check("t5_period6_b", 32'(fifo_level), 32'd1);

        // Mid-stream reset.
        do_reset();
        en_i = 1'b1;
        cyc(1);
        en_i = 1'b0;
        push_n(32'h7FFF_7FFF, 8);
        en_i = 1'b1;
        cyc(1);
        div_i = 18'd1000;
        cyc(2);
        check("t6_pre_level",    32'(fifo_level), 32'd7);
        check("t6_pre_underrun", 32'(underrun_o), 32'd1);
        check("t6_pre_pwm",      32'(pwm_o),      32'd3);
        reset = 1'b1;
        cyc(1);
        check("t6_level",    32'(fifo_level), 32'd0);
        check("t6_full",     32'(fifo_full),  32'd0);
        check("t6_underrun", 32'(underrun_o), 32'd0);
        check("t6_pwm",      32'(pwm_o),      32'd0);
        reset = 1'b0;

`ifdef PCM_DAC_VOLUME_EN
        // vol 128 halves 0x4000 to 0x2000: offset 0xA000 -> 20 of 32; ch1 midscale -> 16 of 32.
        do_reset();
        vol_i = 8'd128;
        push_n(32'h0000_4000, 1);
        en_i = 1'b1;
        cyc(1);
        div_i = 18'd1000;
        cyc(3);
        h0 = 0;
        h1 = 0;
        for (int i = 0; i < 32; i++) begin
            cyc(1);
            h0 += int'(pwm_o[0]);
            h1 += int'(pwm_o[1]);
        end
        check("t7_vol_ch0", 32'(h0), 32'd20);
        check("t7_vol_ch1", 32'(h1), 32'd16);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
